// File: rtl/amplitude_ram_control_if.sv
`default_nettype none
// ============================================================================
// amplitude_ram_control_if : request/response bundle of the amplitude RAM arbiter
// Rev 1.0
// ============================================================================
interface amplitude_ram_control_if #(
  parameter int NUM_QUBIT   = 3,
  parameter int COMPLEX_BIT = 24
);
  localparam int W = 2 * COMPLEX_BIT;

  logic                 init_write_en;
  logic [NUM_QUBIT-1:0] init_address;
  logic [W-1:0]         init_data;
  logic                 start_pass;
  logic                 done_alpha;
  logic                 ram_amplitude_writein_en;
  logic [NUM_QUBIT-1:0] ram_amplitude_writein_address;
  logic [W-1:0]         ram_amplitude_writein;
  logic                 generator_address_valid;
  logic [NUM_QUBIT-1:0] generator_amplitude_address;
  logic                 ram_amplitude_beta_readout_en;
  logic [NUM_QUBIT-1:0] ram_amplitude_beta_readout_address;
  logic                 ram_amplitude_beta_writein_en;
  logic [NUM_QUBIT-1:0] ram_amplitude_beta_writein_address;
  logic [W-1:0]         ram_amplitude_beta_writein;
  logic [W-1:0]         ram_amplitude_out;
  logic                 ram_amplitude_out_valid;
  logic                 busy;
  logic                 copy_done;
  logic                 bank_sel;
  logic                 access_error;

  modport slave (
    input  init_write_en, init_address, init_data, start_pass, done_alpha,
    input  ram_amplitude_writein_en, ram_amplitude_writein_address, ram_amplitude_writein,
    input  generator_address_valid, generator_amplitude_address,
    input  ram_amplitude_beta_readout_en, ram_amplitude_beta_readout_address,
    input  ram_amplitude_beta_writein_en, ram_amplitude_beta_writein_address,
    input  ram_amplitude_beta_writein,
    output ram_amplitude_out, ram_amplitude_out_valid, busy, copy_done, bank_sel, access_error
  );

  modport master (
    output init_write_en, init_address, init_data, start_pass, done_alpha,
    output ram_amplitude_writein_en, ram_amplitude_writein_address, ram_amplitude_writein,
    output generator_address_valid, generator_amplitude_address,
    output ram_amplitude_beta_readout_en, ram_amplitude_beta_readout_address,
    output ram_amplitude_beta_writein_en, ram_amplitude_beta_writein_address,
    output ram_amplitude_beta_writein,
    input  ram_amplitude_out, ram_amplitude_out_valid, busy, copy_done, bank_sel, access_error
  );
endinterface
`default_nettype wire

// File: rtl/amplitude_ram_control.sv
`default_nettype none
// ============================================================================
// amplitude_ram_control : double-banked amplitude store with alpha/beta arbitration
// Rev 1.0
// ============================================================================
module amplitude_ram_control #(
  parameter int NUM_QUBIT   = 3,
  parameter int COMPLEX_BIT = 24
) (
  input  wire logic              clk,
  input  wire logic              rst,
  amplitude_ram_control_if.slave bus
);
  localparam int DEPTH = 2 ** NUM_QUBIT;
  localparam int W     = 2 * COMPLEX_BIT;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_COPY = 2'd1,
    S_PASS = 2'd2,
    S_SWAP = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [NUM_QUBIT-1:0] cnt_q, cnt_d;
  logic                 bank_sel_q;
  logic [W-1:0]         out_q;
  logic                 out_valid_q;
  logic                 copy_done_q;
  logic                 access_error_q;
  logic [W-1:0]         mem_q [2][DEPTH];

  logic                 w_idle, w_pass, w_copy_last;
  logic                 w_init_ok, w_beta_wr_ok, w_act_we;
  logic [NUM_QUBIT-1:0] w_act_addr;
  logic [W-1:0]         w_act_data;
  logic                 w_gen_ok, w_beta_rd_ok, w_rd_en;
  logic [NUM_QUBIT-1:0] w_rd_addr;
  logic [W-1:0]         w_rd_data;
  logic                 w_alpha_ok, w_err;

  assign w_idle = (state_q == S_IDLE);
  assign w_pass = (state_q == S_PASS);

  // Active-bank writes only happen in IDLE; init wins over a beta write.
  assign w_init_ok    = bus.init_write_en & w_idle;
  assign w_beta_wr_ok = bus.ram_amplitude_beta_writein_en & w_idle & ~bus.init_write_en;
  assign w_act_we     = w_init_ok | w_beta_wr_ok;
  assign w_act_addr   = w_init_ok ? bus.init_address : bus.ram_amplitude_beta_writein_address;
  assign w_act_data   = w_init_ok ? bus.init_data    : bus.ram_amplitude_beta_writein;

  // A generator request always wins the read port, even if it is itself illegal.
  assign w_gen_ok     = bus.generator_address_valid & w_pass;
  assign w_beta_rd_ok = bus.ram_amplitude_beta_readout_en & w_idle & ~bus.generator_address_valid;
  assign w_rd_en      = w_gen_ok | w_beta_rd_ok;
  assign w_rd_addr    = w_gen_ok ? bus.generator_amplitude_address
                                 : bus.ram_amplitude_beta_readout_address;
  assign w_rd_data    = (w_act_we && (w_act_addr == w_rd_addr)) ? w_act_data
                                                                 : mem_q[bank_sel_q][w_rd_addr];

  assign w_alpha_ok = bus.ram_amplitude_writein_en & w_pass;

  assign w_err = (bus.ram_amplitude_writein_en      & ~w_pass)
               | (bus.generator_address_valid       & ~w_pass)
               | (bus.ram_amplitude_beta_readout_en & ~w_idle)
               | (bus.ram_amplitude_beta_readout_en & bus.generator_address_valid)
               | (bus.ram_amplitude_beta_writein_en & ~w_idle)
               | (bus.init_write_en                 & ~w_idle)
               | (bus.init_write_en                 & bus.ram_amplitude_beta_writein_en)
               | (bus.start_pass                    & ~w_idle)
               | (bus.done_alpha                    & ~w_pass);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    w_copy_last = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start_pass) begin
          state_d = S_COPY;
          cnt_d   = '0;
        end
      end
      S_COPY: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == '1) begin
          state_d     = S_PASS;
          w_copy_last = 1'b1;
        end
      end
      S_PASS: begin
        if (bus.done_alpha) state_d = S_SWAP;
      end
      S_SWAP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      bank_sel_q     <= 1'b0;
      out_q          <= '0;
      out_valid_q    <= 1'b0;
      copy_done_q    <= 1'b0;
      access_error_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      copy_done_q    <= w_copy_last;
      access_error_q <= access_error_q | w_err;
      out_valid_q    <= w_rd_en;
      if (w_rd_en) out_q <= w_rd_data;
      if (state_q == S_SWAP) bank_sel_q <= ~bank_sel_q;
    end
  end

  // Copy and alpha writes target the shadow bank in disjoint states, so they never collide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < DEPTH; i++) begin
          mem_q[b][i] <= '0;
        end
      end
    end else begin
      if (state_q == S_COPY) mem_q[~bank_sel_q][cnt_q] <= mem_q[bank_sel_q][cnt_q];
      if (w_alpha_ok) mem_q[~bank_sel_q][bus.ram_amplitude_writein_address] <= bus.ram_amplitude_writein;
      if (w_act_we) mem_q[bank_sel_q][w_act_addr] <= w_act_data;
    end
  end

  assign bus.ram_amplitude_out       = out_q;
  assign bus.ram_amplitude_out_valid = out_valid_q;
  assign bus.busy                    = (state_q != S_IDLE);
  assign bus.copy_done               = copy_done_q;
  assign bus.bank_sel                = bank_sel_q;
  assign bus.access_error            = access_error_q;
endmodule
`default_nettype wire

// File: tb/tb_amplitude_ram_control.sv
`default_nettype none
// ============================================================================
// tb_amplitude_ram_control : directed + randomized scoreboard bench
// Rev 1.0
// ============================================================================
module tb_amplitude_ram_control;
  localparam int NQ = 3;
  localparam int CB = 24;
  localparam int D  = 8;
  localparam int M_IDLE = 0, M_COPY = 1, M_PASS = 2, M_SWAP = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  amplitude_ram_control_if #(.NUM_QUBIT(NQ), .COMPLEX_BIT(CB)) ifc ();
  amplitude_ram_control #(.NUM_QUBIT(NQ), .COMPLEX_BIT(CB)) dut (.clk(clk), .rst(rst), .bus(ifc.slave));

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // Reference model: two banks, a mode, and a copy countdown.
  logic [47:0] m_bank [2][D];
  logic        m_sel, m_err, m_valid, m_copy_done;
  logic [47:0] m_out;
  int          m_mode, m_copy_left;
  logic [47:0] exp_q [$];

  // Stimulus for the next cycle
  bit          s_init, s_start, s_done, s_aw, s_gen, s_brd, s_bwr;
  logic [2:0]  s_init_a, s_aw_a, s_gen_a, s_brd_a, s_bwr_a;
  logic [47:0] s_init_d, s_aw_d, s_bwr_d;

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < 2; b++) for (int i = 0; i < D; i++) m_bank[b][i] = '0;
    m_sel = 0; m_err = 0; m_valid = 0; m_copy_done = 0; m_out = '0;
    m_mode = M_IDLE; m_copy_left = 0;
    exp_q.delete();
  endtask

  task automatic clear_stim();
    {s_init, s_start, s_done, s_aw, s_gen, s_brd, s_bwr} = '0;
    {s_init_a, s_aw_a, s_gen_a, s_brd_a, s_bwr_a} = '0;
    {s_init_d, s_aw_d, s_bwr_d} = '0;
  endtask

  task automatic drive();
    ifc.init_write_en                      = s_init;
    ifc.init_address                       = s_init_a;
    ifc.init_data                          = s_init_d;
    ifc.start_pass                         = s_start;
    ifc.done_alpha                         = s_done;
    ifc.ram_amplitude_writein_en           = s_aw;
    ifc.ram_amplitude_writein_address      = s_aw_a;
    ifc.ram_amplitude_writein              = s_aw_d;
    ifc.generator_address_valid            = s_gen;
    ifc.generator_amplitude_address        = s_gen_a;
    ifc.ram_amplitude_beta_readout_en      = s_brd;
    ifc.ram_amplitude_beta_readout_address = s_brd_a;
    ifc.ram_amplitude_beta_writein_en      = s_bwr;
    ifc.ram_amplitude_beta_writein_address = s_bwr_a;
    ifc.ram_amplitude_beta_writein         = s_bwr_d;
  endtask

  // Called at a negedge: applies s_*, advances the model over the next posedge.
  task automatic step();
    bit idle, pass, rd, aw;
    logic [2:0] ra, aa;
    logic [47:0] ad;
    drive();
    idle = (m_mode == M_IDLE);
    pass = (m_mode == M_PASS);
    rd = 0; ra = '0; aw = 0; aa = '0; ad = '0;
    if (s_gen && pass) begin rd = 1; ra = s_gen_a; end
    else if (s_brd && idle && !s_gen) begin rd = 1; ra = s_brd_a; end
    if (idle && s_init) begin aw = 1; aa = s_init_a; ad = s_init_d; end
    else if (idle && s_bwr) begin aw = 1; aa = s_bwr_a; ad = s_bwr_d; end
    m_valid = rd;
    if (rd) begin
      m_out = (aw && aa == ra) ? ad : m_bank[m_sel][ra];
      exp_q.push_back(m_out);
    end
    if ((s_aw && !pass) || (s_gen && !pass) || (s_brd && !idle) || (s_brd && s_gen) ||
        (s_bwr && !idle) || (s_init && !idle) || (s_init && s_bwr) ||
        (s_start && !idle) || (s_done && !pass)) m_err = 1;
    if (aw) m_bank[m_sel][aa] = ad;
    if (pass && s_aw) m_bank[m_sel ^ 1'b1][s_aw_a] = s_aw_d;
    m_copy_done = 0;
    case (m_mode)
      M_IDLE: if (s_start) begin
        for (int i = 0; i < D; i++) m_bank[m_sel ^ 1'b1][i] = m_bank[m_sel][i];
        m_copy_left = D;
        m_mode = M_COPY;
      end
      M_COPY: begin
        m_copy_left--;
        if (m_copy_left == 0) begin m_mode = M_PASS; m_copy_done = 1; end
      end
      M_PASS: if (s_done) m_mode = M_SWAP;
      default: begin m_sel = m_sel ^ 1'b1; m_mode = M_IDLE; end
    endcase
    @(negedge clk);
    clear_stim();
    drive();
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    chk_en = 0;
    @(negedge clk);
    rst = 1;
    #1;
    check("rst_busy", {47'd0, ifc.busy}, 48'd0);
    check("rst_bank_sel", {47'd0, ifc.bank_sel}, 48'd0);
    check("rst_access_error", {47'd0, ifc.access_error}, 48'd0);
    check("rst_copy_done", {47'd0, ifc.copy_done}, 48'd0);
    check("rst_valid", {47'd0, ifc.ram_amplitude_out_valid}, 48'd0);
    check("rst_out", ifc.ram_amplitude_out, 48'd0);
    model_reset();
    @(negedge clk);
    rst = 0;
    chk_en = 1;
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents read data.
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      check("out_valid", {47'd0, ifc.ram_amplitude_out_valid}, {47'd0, m_valid});
      if (ifc.ram_amplitude_out_valid) begin
        if (exp_q.size() == 0) check("read_unexpected", ifc.ram_amplitude_out, 48'hxxxx_xxxx_xxxx);
        else check("read_data", ifc.ram_amplitude_out, exp_q.pop_front());
      end else begin
        check("out_hold", ifc.ram_amplitude_out, m_out);
      end
      check("busy", {47'd0, ifc.busy}, {47'd0, m_mode != M_IDLE});
      check("copy_done", {47'd0, ifc.copy_done}, {47'd0, m_copy_done});
      check("bank_sel", {47'd0, ifc.bank_sel}, {47'd0, m_sel});
      check("access_error", {47'd0, ifc.access_error}, {47'd0, m_err});
    end
  end

  task automatic rand_stim();
    logic [63:0] r;
    s_init  = ($urandom_range(0, 99) < 20);
    s_start = ($urandom_range(0, 99) < 8);
    s_done  = ($urandom_range(0, 99) < 8);
    s_aw    = ($urandom_range(0, 99) < 30);
    s_gen   = ($urandom_range(0, 99) < 35);
    s_brd   = !s_gen && ($urandom_range(0, 99) < 35);
    s_bwr   = ($urandom_range(0, 99) < 25);
    s_init_a = 3'($urandom_range(0, 7)); s_aw_a = 3'($urandom_range(0, 7));
    s_gen_a  = 3'($urandom_range(0, 7)); s_brd_a = 3'($urandom_range(0, 7));
    s_bwr_a  = 3'($urandom_range(0, 7));
    r = {$urandom(), $urandom()}; s_init_d = r[47:0];
    r = {$urandom(), $urandom()}; s_aw_d   = r[47:0];
    r = {$urandom(), $urandom()}; s_bwr_d  = r[47:0];
  endtask

  initial begin
    clear_stim();
    drive();
    model_reset();
    do_reset();
    // Initial load and a beta read-back
    s_init = 1; s_init_a = 3'd0; s_init_d = 48'h000800_000000; step();
    s_init = 1; s_init_a = 3'd5; s_init_d = 48'h000000_000800; step();
    s_brd = 1; s_brd_a = 3'd5; step();
    idle_steps(1);
    // Copy, then pass isolation
    s_start = 1; step();
    idle_steps(D);
    s_gen = 1; s_gen_a = 3'd0; step();
    s_aw = 1; s_aw_a = 3'd0; s_aw_d = 48'h000400_000400; step();
    s_gen = 1; s_gen_a = 3'd0; step();
    // Swap, then read the new active bank
    s_done = 1; step();
    idle_steps(2);
    s_brd = 1; s_brd_a = 3'd0; step();
    s_brd = 1; s_brd_a = 3'd5; step();
    // Write-first forwarding
    s_bwr = 1; s_bwr_a = 3'd3; s_bwr_d = 48'h123456_654321; s_brd = 1; s_brd_a = 3'd3; step();
    idle_steps(1);
    // Illegal generator read in IDLE sets the sticky error
    s_gen = 1; s_gen_a = 3'd1; step();
    idle_steps(2);
    // Read-port contention in PASS and alpha write coinciding with done_alpha
    s_start = 1; step();
    idle_steps(D);
    s_gen = 1; s_gen_a = 3'd3; s_brd = 1; s_brd_a = 3'd5; step();
    s_done = 1; s_aw = 1; s_aw_a = 3'd6; s_aw_d = 48'hABCDEF_FEDCBA; step();
    idle_steps(2);
    s_brd = 1; s_brd_a = 3'd6; step();
    idle_steps(1);
    // Abort mid-copy
    s_start = 1; step();
    idle_steps(4);
    do_reset();
    for (int i = 0; i < D; i++) begin s_brd = 1; s_brd_a = 3'(i); step(); end
    // Randomized traffic with one reset in between
    for (int i = 0; i < 600; i++) begin
      if (i == 300) do_reset();
      rand_stim();
      step();
    end
    idle_steps(2);
    check("scoreboard_empty", 48'(exp_q.size()), 48'd0);
    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire
